cp0_timer_int: RTL and testbench

Interrupt source stage that directly feeds the `int_i[5:0]` input of the CP0 register file. It owns the CP0 Count (reg 9) and Compare (reg 11) registers and generates the timer interrupt. It also synchronises the six asynchronous hardware interrupt lines. It shares the mtc0/mfc0 write and read buses with the CP0 register file, so Count and Compare are software-visible at their architectural addresses.

---
 rtl/cp0_defs.sv | 19 +
 rtl/int_sync.sv | 25 ++
 rtl/cp0_timer_int.sv | 86 ++++++++
 tb/tb_cp0_timer_int.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cp0_defs.sv
// Constants shared by the CP0 register file and the CP0 interrupt sources.
package cp0_defs;

  localparam int unsigned IntW = 6;

  localparam logic [4:0] RegBadVAddr = 5'd8;
  localparam logic [4:0] RegCount    = 5'd9;
  localparam logic [4:0] RegCompare  = 5'd11;
  localparam logic [4:0] RegStatus   = 5'd12;
  localparam logic [4:0] RegCause    = 5'd13;
  localparam logic [4:0] RegEpc      = 5'd14;

  typedef enum logic [4:0] {
    ExcInt  = 5'h00,
    ExcNone = 5'h10,
    ExcEret = 5'h11
  } exc_code_e;

endpackage

// File: rtl/int_sync.sv
// N-stage, W-bit flop synchroniser with synchronous active-high clear.
module int_sync #(
  parameter int unsigned W = 6,
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] stage_q [N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(N); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q = stage_q[N-1];

endmodule

// File: rtl/cp0_timer_int.sv
// CP0 Count/Compare timer plus hardware-interrupt synchronisation feeding the CP0 int_i vector.
module cp0_timer_int
  import cp0_defs::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned COUNT_DIV     = 2,
  parameter int unsigned TIMER_IRQ_BIT = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [31:0]     wdata,
  input  logic            re,
  input  logic [4:0]      raddr,
  input  logic [IntW-1:0] hw_int_i,
  output logic [31:0]     data_o,
  output logic [IntW-1:0] int_o,
  output logic            timer_int_o
);

  localparam int unsigned PreW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

  logic [31:0]     count_q, compare_q, count_inc;
  logic [PreW-1:0] pre_q;
  logic            timer_pend_q;
  logic            tick, count_we, compare_we, match;
  logic [IntW-1:0] hw_sync;

  assign tick       = (pre_q == PreW'(COUNT_DIV - 1));
  assign count_we   = we && (waddr == RegCount);
  assign compare_we = we && (waddr == RegCompare);
  assign count_inc  = count_q + 32'd1;
  // Only a genuine increment can match; a direct Count load never raises the timer.
  assign match      = tick && !count_we && (count_inc == compare_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q      <= '0;
      compare_q    <= '0;
      pre_q        <= '0;
      timer_pend_q <= 1'b0;
    end else begin
      if (count_we) begin
        count_q <= wdata;
        pre_q   <= '0;
      end else if (tick) begin
        count_q <= count_inc;
        pre_q   <= '0;
      end else begin
        pre_q   <= pre_q + PreW'(1);
      end

      if (compare_we) begin
        compare_q    <= wdata;
        timer_pend_q <= 1'b0;
      end else if (match) begin
        timer_pend_q <= 1'b1;
      end
    end
  end

  int_sync #(
    .W(IntW),
    .N(SYNC_STAGES)
  ) u_int_sync (
    .clk(clk),
    .rst(rst),
    .d  (hw_int_i),
    .q  (hw_sync)
  );

  always_comb begin
    int_o                = hw_sync;
    int_o[TIMER_IRQ_BIT] = hw_sync[TIMER_IRQ_BIT] | timer_pend_q;
  end

  assign timer_int_o = timer_pend_q;

  always_comb begin
    data_o = '0;
    if (re && (raddr == RegCount))        data_o = count_q;
    else if (re && (raddr == RegCompare)) data_o = compare_q;
  end

endmodule

// File: tb/tb_cp0_timer_int.sv
// Directed self-checking bench for cp0_timer_int with default parameters.
module tb_cp0_timer_int;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr;
  logic [5:0]  hw_int_i;
  logic [31:0] data_o;
  logic [5:0]  int_o;
  logic        timer_int_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cp0_timer_int dut (
    .clk        (clk),
    .rst        (rst),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .re         (re),
    .raddr      (raddr),
    .hw_int_i   (hw_int_i),
    .data_o     (data_o),
    .int_o      (int_o),
    .timer_int_o(timer_int_o)
  );

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; waddr = a; wdata = d;
    cyc(1);
    we = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    re = 1'b1; raddr = 5'd9; #1;
    checks++;
    if (data_o !== 32'd0) begin errors++; $display("FAIL reset_count got %h want 0", data_o); end
    raddr = 5'd11; #1;
    checks++;
    if (data_o !== 32'd0) begin errors++; $display("FAIL reset_compare got %h want 0", data_o); end
    checks++;
    if (int_o !== 6'd0 || timer_int_o !== 1'b0) begin
      errors++; $display("FAIL reset_int got int_o=%h timer=%b want 0/0", int_o, timer_int_o);
    end
    re = 1'b0; #1;
    checks++;
    if (data_o !== 32'd0) begin errors++; $display("FAIL reset_noread got %h want 0", data_o); end
    cyc(10);
    re = 1'b1; raddr = 5'd9; #1;
    checks++;
    if (data_o !== 32'd5) begin errors++; $display("FAIL count_10cyc got %0d want 5", data_o); end
    raddr = 5'd12; #1;
    checks++;
    if (data_o !== 32'd0) begin errors++; $display("FAIL other_addr got %h want 0", data_o); end
    raddr = 5'd9;
  endtask

  task automatic test_timer_match;
    wr(5'd11, 32'h8);
    wr(5'd9, 32'h5);
    cyc(5);
    checks++;
    if (timer_int_o !== 1'b0 || data_o !== 32'd7) begin
      errors++; $display("FAIL pre_match got timer=%b count=%0d want 0/7", timer_int_o, data_o);
    end
    cyc(1);
    checks++;
    if (timer_int_o !== 1'b1) begin errors++; $display("FAIL match_pend got %b want 1", timer_int_o); end
    checks++;
    if (data_o !== 32'd8) begin errors++; $display("FAIL match_count got %0d want 8", data_o); end
    checks++;
    if (int_o !== 6'h20) begin errors++; $display("FAIL match_int got %h want 20", int_o); end
    cyc(3);
    checks++;
    if (timer_int_o !== 1'b1) begin errors++; $display("FAIL pend_sticky got %b want 1", timer_int_o); end
    wr(5'd11, 32'h100);
    checks++;
    if (timer_int_o !== 1'b0 || int_o !== 6'h0) begin
      errors++; $display("FAIL compare_clear got timer=%b int=%h want 0/00", timer_int_o, int_o);
    end
  endtask

  task automatic test_wrap;
    wr(5'd11, 32'h0);
    wr(5'd9, 32'hFFFF_FFFF);
    cyc(1);
    checks++;
    if (data_o !== 32'hFFFF_FFFF || timer_int_o !== 1'b0) begin
      errors++; $display("FAIL wrap_before got count=%h timer=%b want ffffffff/0", data_o, timer_int_o);
    end
    cyc(1);
    checks++;
    if (data_o !== 32'h0 || timer_int_o !== 1'b1) begin
      errors++; $display("FAIL wrap_after got count=%h timer=%b want 00000000/1", data_o, timer_int_o);
    end
  endtask

  task automatic test_compare_wins;
    wr(5'd11, 32'd10);
    wr(5'd9, 32'd9);
    cyc(1);
    // This edge is a tick where count+1 == compare; the Compare write must win.
    wr(5'd11, 32'd10);
    checks++;
    if (data_o !== 32'd10 || timer_int_o !== 1'b0) begin
      errors++; $display("FAIL cmp_wins got count=%0d timer=%b want 10/0", data_o, timer_int_o);
    end
    cyc(4);
    checks++;
    if (data_o !== 32'd12 || timer_int_o !== 1'b0) begin
      errors++; $display("FAIL cmp_wins_after got count=%0d timer=%b want 12/0", data_o, timer_int_o);
    end
    wr(5'd9, 32'd10);
    checks++;
    if (data_o !== 32'd10 || timer_int_o !== 1'b0) begin
      errors++; $display("FAIL load_eq got count=%0d timer=%b want 10/0", data_o, timer_int_o);
    end
    cyc(4);
    checks++;
    if (data_o !== 32'd12 || timer_int_o !== 1'b0) begin
      errors++; $display("FAIL load_eq_after got count=%0d timer=%b want 12/0", data_o, timer_int_o);
    end
  endtask

  task automatic test_hw_sync;
    hw_int_i = 6'h03;
    cyc(1);
    checks++;
    if (int_o !== 6'h00) begin errors++; $display("FAIL sync_1edge got %h want 00", int_o); end
    cyc(1);
    checks++;
    if (int_o !== 6'h03) begin errors++; $display("FAIL sync_2edge got %h want 03", int_o); end
    hw_int_i = 6'h00;
    cyc(1);
    checks++;
    if (int_o !== 6'h03) begin errors++; $display("FAIL drop_1edge got %h want 03", int_o); end
    cyc(1);
    checks++;
    if (int_o !== 6'h00) begin errors++; $display("FAIL drop_2edge got %h want 00", int_o); end
    hw_int_i = 6'h0C;
    cyc(1);
    rst = 1'b1;
    cyc(1);
    checks++;
    if (int_o !== 6'h00) begin errors++; $display("FAIL rst_midsync got %h want 00", int_o); end
    rst = 1'b0;
    hw_int_i = 6'h00;
    cyc(2);
    checks++;
    if (int_o !== 6'h00 || data_o !== 32'd1) begin
      errors++; $display("FAIL rst_flush got int=%h count=%0d want 00/1", int_o, data_o);
    end
  endtask

  task automatic test_rw_same;
    wr(5'd9, 32'h50);
    we = 1'b1; waddr = 5'd9; wdata = 32'h1234;
    re = 1'b1; raddr = 5'd9; #1;
    checks++;
    if (data_o !== 32'h50) begin errors++; $display("FAIL rw_old got %h want 50", data_o); end
    cyc(1);
    we = 1'b0; #1;
    checks++;
    if (data_o !== 32'h1234) begin errors++; $display("FAIL rw_new got %h want 1234", data_o); end
    cyc(1);
    checks++;
    if (data_o !== 32'h1234) begin errors++; $display("FAIL rw_hold got %h want 1234", data_o); end
    cyc(1);
    checks++;
    if (data_o !== 32'h1235) begin errors++; $display("FAIL rw_incr got %h want 1235", data_o); end
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    re = 1'b0; raddr = '0; hw_int_i = '0;
    #1;
    test_reset();
    test_timer_match();
    test_wrap();
    test_compare_wins();
    test_hw_sync();
    test_rw_same();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
